// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage posted-store buffer.
// Stateless: no latency or backpressure of its own.
package mem_pkg;
   localparam int AW = 6;
   localparam int DW = 32;

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} sb_state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup across all valid buffer entries; youngest match wins.
// Purely combinational: zero latency, no backpressure.
module sb_fwd_match
   import mem_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH)
) (
   input  sb_entry_t [DEPTH-1:0] entries,
   input  logic [PW-1:0]         head,
   input  logic [PW:0]           count,
   input  logic [AW-1:0]         addr,
   output logic                  hit,
   output logic [DW-1:0]         data
);
   // Walk oldest to youngest so later (younger) matches overwrite earlier ones.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (((PW+1)'(k) < count) && (entries[head + PW'(k)].addr == addr)) begin
            hit  = 1'b1;
            data = entries[head + PW'(k)].data;
         end
      end
   end
endmodule

// File: rtl/mem_store_buffer.sv
// Posted-store buffer in front of DataMemory with load forwarding, starvation relief and flush.
// Load response 1 cycle after accept; req_ready drops when full, flushing, or forcing a drain.
module mem_store_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          req_ready,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   input  logic          flush_req,
   output logic          flush_done,
   output logic          sb_empty,
   output logic          dm_MemRead,
   output logic          dm_MemWrite,
   output logic [AW-1:0] dm_Address,
   output logic [DW-1:0] dm_WriteData,
   input  logic [DW-1:0] dm_ReadData
);
   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_MAX + 1);

   sb_entry_t [DEPTH-1:0] entries;
   logic [PW-1:0]         head, tail;
   logic [PW:0]           count;
   logic [SW-1:0]         starve_cnt;
   sb_state_t             state, state_next;

   logic          empty, full, force_drain;
   logic          push, pop, load_acc;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;

   assign empty       = (count == '0);
   assign full        = (count == (PW+1)'(DEPTH));
   assign force_drain = (state == RUN) && !empty && (starve_cnt == SW'(STARVE_MAX));
   assign sb_empty    = empty;

   // rst_n gates ready so nothing is accepted while reset is held.
   assign req_ready = rst_n && (state == RUN) && (req_we ? !full : !force_drain);
   assign push      = req_valid && req_ready && req_we;
   assign load_acc  = req_valid && req_ready && !req_we;
   assign pop       = !load_acc && !empty;

   always_comb begin
      dm_MemRead   = 1'b0;
      dm_MemWrite  = 1'b0;
      dm_Address   = '0;
      dm_WriteData = '0;
      if (load_acc) begin
         dm_MemRead = 1'b1;
         dm_Address = req_addr;
      end else if (!empty) begin
         dm_MemWrite  = 1'b1;
         dm_Address   = entries[head].addr;
         dm_WriteData = entries[head].data;
      end
   end

   sb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
      .entries (entries),
      .head    (head),
      .count   (count),
      .addr    (req_addr),
      .hit     (fwd_hit),
      .data    (fwd_data)
   );

   always_ff @(posedge clk) begin
      if (push) entries[tail] <= '{addr: req_addr, data: req_wdata};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         starve_cnt <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         if (empty || pop)
            starve_cnt <= '0;
         else if (load_acc)
            starve_cnt <= starve_cnt + SW'(1);
         rsp_valid <= load_acc;
         if (load_acc) rsp_rdata <= fwd_hit ? fwd_data : dm_ReadData;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_next;
   end

   // No loads are accepted in FLUSH, so the head always drains there.
   always_comb begin
      state_next = state;
      flush_done = 1'b0;
      case (state)
         RUN:   if (flush_req) state_next = FLUSH;
         FLUSH: if (empty || (count == (PW+1)'(1) && pop)) begin
                   state_next = RUN;
                   flush_done = 1'b1;
                end
         default: state_next = RUN;
      endcase
   end
endmodule

// File: tb/tb_mem_store_buffer.sv
// Randomised + directed bench for mem_store_buffer against a queue-based behavioural model.
// Includes a 64-word DataMemory model driven by the DUT's dm_* port.
module tb_mem_store_buffer;
   import mem_pkg::*;
   localparam int DEPTH = 4;
   localparam int SMAX  = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_we, req_ready, rsp_valid, flush_req, flush_done, sb_empty;
   logic [AW-1:0] req_addr, dm_Address;
   logic [DW-1:0] req_wdata, rsp_rdata, dm_WriteData, dm_ReadData;
   logic          dm_MemRead, dm_MemWrite;

   mem_store_buffer #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .flush_req(flush_req),
      .flush_done(flush_done), .sb_empty(sb_empty), .dm_MemRead(dm_MemRead),
      .dm_MemWrite(dm_MemWrite), .dm_Address(dm_Address), .dm_WriteData(dm_WriteData),
      .dm_ReadData(dm_ReadData)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] dm_mem [64];
   assign dm_ReadData = dm_mem[dm_Address];
   always @(posedge clk) if (dm_MemWrite) dm_mem[dm_Address] <= dm_WriteData;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: a queue of pending stores plus the memory image they produce.
   sb_entry_t     q[$];
   logic [DW-1:0] ref_mem [64];
   int            starve;
   bit            flushing;
   logic          m_rsp_valid;
   logic [DW-1:0] m_rsp_rdata;

   bit            c_load, c_store, c_drain, c_done, c_flush, c_was_empty;
   logic [DW-1:0] c_ldata;
   sb_entry_t     c_entry;

   always @(negedge clk) begin
      c_load = 0; c_store = 0; c_drain = 0; c_done = 0; c_flush = 0; c_was_empty = 1;
      if (!rst_n) begin
         check("rst_req_ready", req_ready, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_rsp_rdata", rsp_rdata, 0);
         check("rst_sb_empty", sb_empty, 1);
         check("rst_dm_write", dm_MemWrite, 0);
         check("rst_dm_read", dm_MemRead, 0);
         check("rst_flush_done", flush_done, 0);
      end else begin
         int  sz;
         bit  full, force_d, e_ready;
         sz          = q.size();
         c_was_empty = (sz == 0);
         full        = (sz == DEPTH);
         force_d     = !flushing && sz > 0 && starve == SMAX;
         e_ready     = !flushing && (req_we ? !full : !force_d);
         c_load      = req_valid && e_ready && !req_we;
         c_store     = req_valid && e_ready && req_we;
         c_drain     = !c_load && sz > 0;
         c_done      = flushing && sz <= 1;
         c_flush     = flush_req;
         c_entry     = '{addr: req_addr, data: req_wdata};
         if (c_load) begin
            c_ldata = ref_mem[req_addr];
            for (int i = 0; i < sz; i++) if (q[i].addr == req_addr) c_ldata = q[i].data;
         end
         check("req_ready", req_ready, e_ready);
         check("sb_empty", sb_empty, sz == 0);
         check("flush_done", flush_done, c_done);
         check("rsp_valid", rsp_valid, m_rsp_valid);
         check("rsp_rdata", rsp_rdata, m_rsp_rdata);
         check("dm_MemRead", dm_MemRead, c_load);
         check("dm_MemWrite", dm_MemWrite, c_drain);
         if (c_load) check("dm_Address_rd", dm_Address, req_addr);
         else if (c_drain) begin
            check("dm_Address_wr", dm_Address, q[0].addr);
            check("dm_WriteData", dm_WriteData, q[0].data);
         end else begin
            check("dm_Address_idle", dm_Address, 0);
            check("dm_WriteData_idle", dm_WriteData, 0);
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         starve = 0; flushing = 0; m_rsp_valid = 0; m_rsp_rdata = '0;
      end else begin
         if (c_drain) begin
            ref_mem[q[0].addr] = q[0].data;
            void'(q.pop_front());
         end
         if (c_store) q.push_back(c_entry);
         if (c_was_empty || c_drain) starve = 0;
         else if (c_load) starve++;
         if (flushing && c_done) flushing = 0;
         else if (!flushing && c_flush) flushing = 1;
         m_rsp_valid = c_load;
         if (c_load) m_rsp_rdata = c_ldata;
      end
   end

   task automatic set_in(input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit f);
      req_valid = v; req_we = we; req_addr = a; req_wdata = d; flush_req = f;
   endtask

   // Drive one request for one cycle, then return to idle just after the edge.
   task automatic step(input bit v, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit f);
      set_in(v, we, a, d, f);
      @(posedge clk); #1;
      set_in(0, 0, '0, '0, 0);
   endtask

   initial begin
      bit ready_seen [5];
      bit done_seen;
      for (int i = 0; i < 64; i++) begin dm_mem[i] = '0; ref_mem[i] = '0; end
      rst_n = 1'b0;
      set_in(0, 0, '0, '0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Store then memory-path load
      step(1, 1, 6'd2, 32'h12345678, 0);
      #1;
      check("t2_write_next", dm_MemWrite, 1);
      check("t2_write_addr", dm_Address, 2);
      step(0, 0, '0, '0, 0);
      step(1, 0, 6'd2, '0, 0);
      #1;
      check("t2_rsp_valid", rsp_valid, 1);
      check("t2_rsp_data", rsp_rdata, 32'h12345678);

      // Back-to-back stores to one address, load forwards the younger
      step(1, 1, 6'd3, 32'h87654321, 0);
      step(1, 1, 6'd3, 32'hAAAA5555, 0);
      set_in(1, 0, 6'd3, '0, 0);
      #1;
      check("t3_memread", dm_MemRead, 1);
      check("t3_no_write", dm_MemWrite, 0);
      @(posedge clk); #1;
      set_in(0, 0, '0, '0, 0);
      check("t3_fwd_data", rsp_rdata, 32'hAAAA5555);
      step(0, 0, '0, '0, 0);

      // Starvation relief: ready pattern under continuous loads
      step(1, 1, 6'd5, 32'h0BADF00D, 0);
      for (int i = 0; i < 5; i++) begin
         set_in(1, 0, 6'd7, '0, 0);
         #1 ready_seen[i] = req_ready;
         @(posedge clk); #1;
      end
      set_in(0, 0, '0, '0, 0);
      check("t5_ready0", ready_seen[0], 1);
      check("t5_ready2", ready_seen[2], 1);
      check("t5_ready3_stall", ready_seen[3], 0);
      check("t5_ready4", ready_seen[4], 1);
      check("t5_drained", dm_mem[5], 32'h0BADF00D);

      // Flush: store queued behind a load, then flush until done
      step(1, 1, 6'd9, 32'h99990009, 0);
      step(1, 0, 6'd1, '0, 0);
      done_seen = 0;
      for (int i = 0; i < 10 && !done_seen; i++) begin
         set_in(1, 0, 6'd1, '0, 1);
         #1;
         if (flush_done) begin
            done_seen = 1;
            check("t6_ready_in_flush", req_ready, 0);
         end
         @(posedge clk); #1;
      end
      set_in(0, 0, '0, '0, 0);
      check("t6_flush_done_seen", done_seen, 1);
      check("t6_flushed_data", dm_mem[9], 32'h99990009);
      #1 check("t6_back_to_run", req_ready, 1);

      // Reset with a store queued: it must never reach memory
      step(1, 1, 6'd20, 32'hDEADBEEF, 0);
      set_in(1, 0, 6'd20, '0, 0);
      @(posedge clk); #1;
      set_in(0, 0, '0, '0, 0);
      rst_n = 1'b0;
      #1;
      check("t1_sb_empty", sb_empty, 1);
      check("t1_no_write", dm_MemWrite, 0);
      check("t1_rsp_valid", rsp_valid, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("t1_discarded", dm_mem[20], 0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         set_in(($urandom % 4) != 0, $urandom % 2, 6'($urandom % 8), $urandom,
                ($urandom % 40) == 0);
         if (($urandom % 600) == 0) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      set_in(0, 0, '0, '0, 0);
      repeat (10) @(posedge clk);
      #1;
      for (int i = 0; i < 64; i++) check("final_mem", dm_mem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
